// File: rtl/gamma_lut_ctrl_if.sv
// Signal bundle between the pixel pipeline / host table loader and the gamma LUT controller,
// including the RAM-side port the controller drives.
interface gamma_lut_ctrl_if;
  logic [17:0] iY;
  logic        iValid;
  logic        iSOF;
  logic [11:0] hAddr;
  logic [11:0] hData;
  logic        hWrite;
  logic        hReady;
  logic        hCommit;
  logic        oCommitDone;
  logic        oBank;
  logic        oInitDone;
  logic [12:0] ramAddr;
  logic [11:0] ramData;
  logic        ramWren;
  logic        ramRden;
  logic        oQValid;

  modport master (
    output iY, iValid, iSOF, hAddr, hData, hWrite, hCommit,
    input  hReady, oCommitDone, oBank, oInitDone, ramAddr, ramData, ramWren, ramRden, oQValid
  );

  modport slave (
    input  iY, iValid, iSOF, hAddr, hData, hWrite, hCommit,
    output hReady, oCommitDone, oBank, oInitDone, ramAddr, ramData, ramWren, ramRden, oQValid
  );
endinterface

// File: rtl/gamma_lut_ctrl.sv
// Arbiter for the single-port two-bank gamma LUT RAM: pixel reads win over host table writes,
// identity fill after reset, and an active-bank swap on the first SOF after a host commit.
module gamma_lut_ctrl #(
  parameter int unsigned RD_LAT  = 2,
  parameter bit          INIT_EN = 1'b1
) (
  input logic             clk,
  input logic             reset,
  gamma_lut_ctrl_if.slave bus
);

  localparam logic [12:0] LastInit = 13'h1FFF;

  typedef enum logic [1:0] {StInit, StRun, StPend} state_e;

  state_e            state_q, state_d;
  logic [12:0]       init_cnt_q, init_cnt_d;
  logic              bank_q, bank_d;
  logic              init_done_q, init_done_d;
  logic              commit_done_q, commit_done_d;
  logic [RD_LAT-1:0] qv_q, qv_d;

  // Only the 12 index bits of the luma are looked up.
  logic unused_iy;
  assign unused_iy = ^{bus.iY[17], bus.iY[4:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if (INIT_EN) state_q <= StInit;
      else         state_q <= StRun;
      init_cnt_q    <= '0;
      bank_q        <= 1'b0;
      init_done_q   <= 1'b0;
      commit_done_q <= 1'b0;
      qv_q          <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      bank_q        <= bank_d;
      init_done_q   <= init_done_d;
      commit_done_q <= commit_done_d;
      qv_q          <= qv_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    bank_d        = bank_q;
    // Without an init phase the flag still rises one cycle after reset.
    init_done_d   = init_done_q | (state_q != StInit);
    commit_done_d = 1'b0;
    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 13'd1;
        if (init_cnt_q == LastInit) begin
          state_d     = StRun;
          init_done_d = 1'b1;
        end
      end
      StRun: begin
        if (bus.hCommit) state_d = StPend;
      end
      StPend: begin
        if (bus.iSOF) begin
          bank_d        = ~bank_q;
          state_d       = StRun;
          commit_done_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Read-valid pipeline matching the RAM read latency.
  always_comb begin
    qv_d    = '0;
    qv_d[0] = bus.iValid && (state_q != StInit);
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      qv_d[i] = qv_q[i-1];
    end
  end

  always_comb begin
    bus.ramAddr = '0;
    bus.ramData = '0;
    bus.ramWren = 1'b0;
    bus.ramRden = 1'b0;
    if (state_q == StInit) begin
      bus.ramAddr = init_cnt_q;
      bus.ramData = init_cnt_q[11:0];
      bus.ramWren = 1'b1;
    end else if (bus.iValid) begin
      bus.ramAddr = {bank_q, bus.iY[16:5]};
      bus.ramRden = 1'b1;
    end else if ((state_q == StRun) && bus.hWrite) begin
      // Host only ever loads the bank the pixels are not reading.
      bus.ramAddr = {~bank_q, bus.hAddr};
      bus.ramData = bus.hData;
      bus.ramWren = 1'b1;
    end
  end

  assign bus.hReady      = (state_q == StRun) && !bus.iValid;
  assign bus.oBank       = bank_q;
  assign bus.oInitDone   = init_done_q;
  assign bus.oCommitDone = commit_done_q;
  assign bus.oQValid     = qv_q[RD_LAT-1];

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Self-checking bench for gamma_lut_ctrl: randomized traffic against a cycle-level model of the
// arbitration, init fill, commit/swap and read-valid latency rules.
module tb_gamma_lut_ctrl;
  localparam int RdLat     = 2;
  localparam int InitWords = 8192;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  gamma_lut_ctrl_if bus ();

  gamma_lut_ctrl #(
    .RD_LAT (RdLat),
    .INIT_EN(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int m_init_left;
  bit m_bank, m_pending, m_init_done, m_commit_pulse;
  bit m_qv[$];

  typedef struct packed {
    logic [12:0] addr;
    logic [11:0] data;
    logic        wren;
    logic        rden;
    logic        hready;
  } exp_t;

  task automatic model_reset();
    m_init_left    = InitWords;
    m_bank         = 1'b0;
    m_pending      = 1'b0;
    m_init_done    = 1'b0;
    m_commit_pulse = 1'b0;
    m_qv.delete();
    repeat (RdLat) m_qv.push_back(1'b0);
  endtask

  task automatic model_step();
    bit in_init;
    bit dropped;
    in_init = (m_init_left > 0);
    m_qv.push_back(bus.iValid && !in_init);
    dropped = m_qv.pop_front();
    m_commit_pulse = 1'b0;
    if (in_init) begin
      m_init_left--;
      if (m_init_left == 0) m_init_done = 1'b1;
    end else if (m_pending) begin
      if (bus.iSOF) begin
        m_bank         = !m_bank;
        m_pending      = 1'b0;
        m_commit_pulse = 1'b1;
      end
    end else if (bus.hCommit) begin
      m_pending = 1'b1;
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    e = '0;
    if (m_init_left > 0) begin
      e.wren = 1'b1;
      e.addr = 13'(InitWords - m_init_left);
      e.data = e.addr[11:0];
    end else if (bus.iValid) begin
      e.rden = 1'b1;
      e.addr = {m_bank, bus.iY[16:5]};
    end else if (!m_pending && bus.hWrite) begin
      e.wren = 1'b1;
      e.addr = {!m_bank, bus.hAddr};
      e.data = bus.hData;
    end
    e.hready = (m_init_left == 0) && !m_pending && !bus.iValid;
    return e;
  endfunction

  task automatic clock_edge();
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic drive_idle();
    bus.iY      = '0;
    bus.iValid  = 1'b0;
    bus.iSOF    = 1'b0;
    bus.hAddr   = '0;
    bus.hData   = '0;
    bus.hWrite  = 1'b0;
    bus.hCommit = 1'b0;
  endtask

  // Finish any pending swap so the next scenario starts from RUN.
  task automatic settle_run();
    drive_idle();
    if (m_pending) begin
      bus.iSOF   = 1'b1;
      bus.iValid = 1'b1;
      clock_edge();
      drive_idle();
    end
    repeat (RdLat + 1) clock_edge();
  endtask

  task automatic test_reset();
    drive_idle();
    model_reset();
    reset = 1'b0;
    repeat (2) clock_edge();
    @(negedge clk);
    checks++;
    if (bus.oBank !== 1'b0 || bus.oInitDone !== 1'b0 || bus.oCommitDone !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags bank=%0b initdone=%0b commitdone=%0b required 0 0 0",
               bus.oBank, bus.oInitDone, bus.oCommitDone);
    end
    checks++;
    if (bus.oQValid !== 1'b0 || bus.hReady !== 1'b0 || bus.ramRden !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs qvalid=%0b hready=%0b rden=%0b required 0 0 0",
               bus.oQValid, bus.hReady, bus.ramRden);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_init();
    for (int k = 0; k < InitWords; k++) begin
      bus.iY      = 18'($urandom);
      bus.iValid  = 1'b1;
      bus.iSOF    = 1'($urandom_range(0, 1));
      bus.hCommit = 1'($urandom_range(0, 1));
      bus.hWrite  = 1'($urandom_range(0, 1));
      bus.hAddr   = 12'($urandom);
      bus.hData   = 12'($urandom);
      @(negedge clk);
      checks++;
      if (bus.ramWren !== 1'b1 || bus.ramRden !== 1'b0 || bus.ramAddr !== 13'(k) ||
          bus.ramData !== 12'(k)) begin
        failures++;
        $display("FAIL init_write cycle=%0d wren=%0b rden=%0b addr=%h data=%h required 1 0 %h %h",
                 k, bus.ramWren, bus.ramRden, bus.ramAddr, bus.ramData, 13'(k), 12'(k));
      end
      checks++;
      if (bus.oQValid !== 1'b0 || bus.hReady !== 1'b0 || bus.oInitDone !== 1'b0 ||
          bus.oCommitDone !== 1'b0) begin
        failures++;
        $display("FAIL init_quiet cycle=%0d qvalid=%0b hready=%0b initdone=%0b commit=%0b req 0",
                 k, bus.oQValid, bus.hReady, bus.oInitDone, bus.oCommitDone);
      end
      clock_edge();
    end
    drive_idle();
    @(negedge clk);
    checks++;
    if (bus.oInitDone !== 1'b1 || bus.hReady !== 1'b1 || bus.ramWren !== 1'b0 ||
        bus.oQValid !== 1'b0 || bus.oBank !== 1'b0) begin
      failures++;
      $display("FAIL init_done initdone=%0b hready=%0b wren=%0b qvalid=%0b bank=%0b req 1 1 0 0 0",
               bus.oInitDone, bus.hReady, bus.ramWren, bus.oQValid, bus.oBank);
    end
    clock_edge();
  endtask

  task automatic test_read_latency();
    drive_idle();
    bus.iY     = 18'h0A5E0;
    bus.iValid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ramAddr !== 13'h052F || bus.ramRden !== 1'b1 || bus.ramWren !== 1'b0) begin
      failures++;
      $display("FAIL read_addr addr=%h rden=%0b wren=%0b required 052f 1 0",
               bus.ramAddr, bus.ramRden, bus.ramWren);
    end
    clock_edge();
    bus.iValid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.oQValid !== 1'b0) begin
      failures++;
      $display("FAIL read_qvalid_early qvalid=%0b required 0", bus.oQValid);
    end
    clock_edge();
    @(negedge clk);
    checks++;
    if (bus.oQValid !== 1'b1) begin
      failures++;
      $display("FAIL read_qvalid_lat2 qvalid=%0b required 1", bus.oQValid);
    end
    clock_edge();
    @(negedge clk);
    checks++;
    if (bus.oQValid !== 1'b0) begin
      failures++;
      $display("FAIL read_qvalid_single qvalid=%0b required 0", bus.oQValid);
    end
    clock_edge();
  endtask

  task automatic test_host_write();
    logic [17:0] y;
    drive_idle();
    y           = 18'($urandom);
    bus.iY      = y;
    bus.hAddr   = 12'h123;
    bus.hData   = 12'hABC;
    bus.hWrite  = 1'b1;
    bus.iValid  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.hReady !== 1'b0 || bus.ramRden !== 1'b1 || bus.ramWren !== 1'b0 ||
        bus.ramAddr !== {1'b0, y[16:5]}) begin
      failures++;
      $display("FAIL hwrite_blocked hready=%0b rden=%0b wren=%0b addr=%h required 0 1 0 %h",
               bus.hReady, bus.ramRden, bus.ramWren, bus.ramAddr, {1'b0, y[16:5]});
    end
    clock_edge();
    bus.iValid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.hReady !== 1'b1 || bus.ramWren !== 1'b1 || bus.ramRden !== 1'b0 ||
        bus.ramAddr !== 13'h1123 || bus.ramData !== 12'hABC) begin
      failures++;
      $display("FAIL hwrite_accept hready=%0b wren=%0b rden=%0b addr=%h data=%h req 1 1 0 1123 abc",
               bus.hReady, bus.ramWren, bus.ramRden, bus.ramAddr, bus.ramData);
    end
    clock_edge();
    drive_idle();
    clock_edge();
  endtask

  task automatic test_random_traffic(input int n);
    exp_t e;
    drive_idle();
    for (int c = 0; c < n; c++) begin
      bus.iValid  = 1'($urandom_range(0, 1));
      bus.iY      = 18'($urandom);
      bus.iSOF    = bus.iValid && ($urandom_range(0, 14) == 0);
      bus.hCommit = ($urandom_range(0, 19) == 0);
      if (!bus.hWrite && $urandom_range(0, 2) != 0) begin
        bus.hWrite = 1'b1;
        bus.hAddr  = 12'($urandom);
        bus.hData  = 12'($urandom);
      end
      @(negedge clk);
      e = model_expect();
      checks++;
      if (bus.hReady !== e.hready || bus.ramWren !== e.wren || bus.ramRden !== e.rden) begin
        failures++;
        $display("FAIL rand_ctrl cycle=%0d hready=%0b wren=%0b rden=%0b required %0b %0b %0b",
                 c, bus.hReady, bus.ramWren, bus.ramRden, e.hready, e.wren, e.rden);
      end
      checks++;
      if ((e.wren || e.rden) && (bus.ramAddr !== e.addr || (e.wren && bus.ramData !== e.data)))
      begin
        failures++;
        $display("FAIL rand_addr cycle=%0d addr=%h data=%h required %h %h",
                 c, bus.ramAddr, bus.ramData, e.addr, e.data);
      end
      checks++;
      if (bus.oQValid !== m_qv[0] || bus.oBank !== m_bank ||
          bus.oCommitDone !== m_commit_pulse) begin
        failures++;
        $display("FAIL rand_status cycle=%0d qvalid=%0b bank=%0b commit=%0b required %0b %0b %0b",
                 c, bus.oQValid, bus.oBank, bus.oCommitDone, m_qv[0], m_bank, m_commit_pulse);
      end
      if (bus.hWrite && e.hready) bus.hWrite = 1'b0;
      clock_edge();
    end
    drive_idle();
  endtask

  task automatic test_commit_swap();
    bit b0;
    int pulses;
    settle_run();
    b0          = m_bank;
    bus.hCommit = 1'b1;
    clock_edge();
    bus.hCommit = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.hWrite = 1'b1;
      bus.hAddr  = 12'($urandom);
      bus.iValid = (c == 2);
      @(negedge clk);
      checks++;
      if (bus.hReady !== 1'b0 || bus.ramWren !== 1'b0 || bus.oCommitDone !== 1'b0 ||
          bus.oBank !== b0) begin
        failures++;
        $display("FAIL pend_block cycle=%0d hready=%0b wren=%0b commit=%0b bank=%0b req 0 0 0 %0b",
                 c, bus.hReady, bus.ramWren, bus.oCommitDone, bus.oBank, b0);
      end
      clock_edge();
    end
    drive_idle();
    bus.iSOF   = 1'b1;
    bus.iValid = 1'b1;
    bus.iY     = 18'($urandom);
    @(negedge clk);
    checks++;
    if (bus.ramAddr[12] !== b0 || bus.ramRden !== 1'b1) begin
      failures++;
      $display("FAIL swap_sof_old_bank bank_bit=%0b rden=%0b required %0b 1",
               bus.ramAddr[12], bus.ramRden, b0);
    end
    clock_edge();
    bus.iSOF = 1'b0;
    bus.iY   = 18'($urandom);
    @(negedge clk);
    checks++;
    if (bus.ramAddr[12] !== !b0 || bus.oBank !== !b0 || bus.oCommitDone !== 1'b1) begin
      failures++;
      $display("FAIL swap_new_bank bank_bit=%0b bank=%0b commit=%0b required %0b %0b 1",
               bus.ramAddr[12], bus.oBank, bus.oCommitDone, !b0, !b0);
    end
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      clock_edge();
      @(negedge clk);
      if (bus.oCommitDone === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL swap_single_pulse extra_pulses=%0d required 0", pulses);
    end
    drive_idle();
    clock_edge();
  endtask

  task automatic test_commit_sof_same();
    bit b0;
    settle_run();
    b0          = m_bank;
    bus.hCommit = 1'b1;
    bus.iSOF    = 1'b1;
    bus.iValid  = 1'b1;
    clock_edge();
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.oBank !== b0 || bus.oCommitDone !== 1'b0 || bus.hReady !== 1'b0) begin
        failures++;
        $display("FAIL same_cycle_no_swap cycle=%0d bank=%0b commit=%0b hready=%0b req %0b 0 0",
                 c, bus.oBank, bus.oCommitDone, bus.hReady, b0);
      end
      clock_edge();
    end
    bus.iSOF   = 1'b1;
    bus.iValid = 1'b1;
    clock_edge();
    drive_idle();
    @(negedge clk);
    checks++;
    if (bus.oBank !== !b0 || bus.oCommitDone !== 1'b1 || bus.hReady !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_later_swap bank=%0b commit=%0b hready=%0b required %0b 1 1",
               bus.oBank, bus.oCommitDone, bus.hReady, !b0);
    end
    clock_edge();
  endtask

  task automatic test_reset_in_pend();
    settle_run();
    if (!m_bank) begin
      bus.hCommit = 1'b1;
      clock_edge();
      drive_idle();
      bus.iSOF   = 1'b1;
      bus.iValid = 1'b1;
      clock_edge();
      drive_idle();
      clock_edge();
    end
    bus.hCommit = 1'b1;
    clock_edge();
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      bus.iValid = 1'b1;
      bus.iY     = 18'($urandom);
      clock_edge();
    end
    drive_idle();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.oBank !== 1'b0 || bus.oInitDone !== 1'b0 || bus.hReady !== 1'b0 ||
        bus.oCommitDone !== 1'b0) begin
      failures++;
      $display("FAIL pend_reset_flags bank=%0b initdone=%0b hready=%0b commit=%0b required 0",
               bus.oBank, bus.oInitDone, bus.hReady, bus.oCommitDone);
    end
    checks++;
    if (bus.ramWren !== 1'b1 || bus.ramAddr !== 13'h0000 || bus.oQValid !== 1'b0) begin
      failures++;
      $display("FAIL pend_reset_ram wren=%0b addr=%h qvalid=%0b required 1 0000 0",
               bus.ramWren, bus.ramAddr, bus.oQValid);
    end
    clock_edge();
    reset = 1'b1;
    for (int k = 0; k < 24; k++) begin
      bus.iValid = 1'b1;
      bus.iSOF   = (k % 4 == 0);
      bus.iY     = 18'($urandom);
      @(negedge clk);
      checks++;
      if (bus.ramWren !== 1'b1 || bus.ramAddr !== 13'(k) || bus.oCommitDone !== 1'b0 ||
          bus.oBank !== 1'b0 || bus.hReady !== 1'b0) begin
        failures++;
        $display("FAIL pend_reset_restart k=%0d wren=%0b addr=%h commit=%0b bank=%0b hready=%0b",
                 k, bus.ramWren, bus.ramAddr, bus.oCommitDone, bus.oBank, bus.hReady);
      end
      clock_edge();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_init();
    test_read_latency();
    test_host_write();
    test_random_traffic(400);
    test_commit_swap();
    test_commit_sof_same();
    test_random_traffic(200);
    test_reset_in_pend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
